// File: rtl/wb_counter_bank.sv
// Wishbone-programmable bank of NCH up/down, periodic/one-shot counters with sticky flags and interrupt.
// Optional shared 8-bit prescaler at word 4*NCH+1 when PRESCALER_EN is defined.
module wb_counter_bank #(
   parameter int NCH  = 4,
   parameter int BITS = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wbs_cyc_i,
   input  logic                wbs_stb_i,
   input  logic                wbs_we_i,
   input  logic [3:0]          wbs_sel_i,
   input  logic [31:0]         wbs_adr_i,
   input  logic [31:0]         wbs_dat_i,
   output logic                wbs_ack_o,
   output logic [31:0]         wbs_dat_o,
   output logic [NCH*BITS-1:0] count_o,
   output logic [NCH-1:0]      tc_o,
   output logic                irq_o
);

   typedef enum logic [1:0] {REG_CTRL, REG_COUNT, REG_RELOAD, REG_RSVD} reg_e;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_DIR     = 1;
   localparam int CTRL_ONESHOT = 2;
   localparam int CTRL_IE      = 3;
   localparam logic [5:0] STATUS_WORD = 6'(4 * NCH);

   logic [3:0]      ctrl       [NCH];
   logic [BITS-1:0] count      [NCH];
   logic [BITS-1:0] reload     [NCH];
   logic [BITS-1:0] count_next [NCH];
   logic [NCH-1:0]  status;
   logic [NCH-1:0]  event_hit;
   logic [NCH-1:0]  ie_vec;
   logic [NCH-1:0]  w1c;
   logic [5:0]      word;
   logic            req_new;
   logic            wr;
   logic            tick;
   logic [31:0]     rd_data;
   logic [31:0]     mask;
   logic [31:0]     wr_val;
   logic            unused_ok;

   assign word    = wbs_adr_i[7:2];
   // A new access is accepted only when no ack is outstanding, giving the 2-cycle minimum.
   assign req_new = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
   assign wr      = req_new & wbs_we_i;
   assign mask    = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
   assign wr_val  = (rd_data & ~mask) | (wbs_dat_i & mask);
   assign w1c     = (wr && word == STATUS_WORD) ? (wbs_dat_i[NCH-1:0] & mask[NCH-1:0]) : '0;
   assign unused_ok = &{1'b0, wbs_adr_i[31:8], wbs_adr_i[1:0], wr_val};

`ifdef PRESCALER_EN
   localparam logic [5:0] PRESCALE_WORD = 6'(4 * NCH + 1);
   logic [7:0] prescale;
   logic [7:0] pre_cnt;

   assign tick = (pre_cnt == prescale);

   always_ff @(posedge clk) begin
      if (reset) begin
         prescale <= '0;
         pre_cnt  <= '0;
      end else if (wr && word == PRESCALE_WORD) begin
         prescale <= wr_val[7:0];
         pre_cnt  <= '0;
      end else begin
         pre_cnt <= tick ? 8'd0 : pre_cnt + 8'd1;
      end
   end
`else
   assign tick = 1'b1;
`endif

   // Current value of the addressed word; also the base for byte-lane merging on writes.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      rd_data = '0;
      for (int c = 0; c < NCH; c++) begin
         if (word[5:2] == 4'(c)) begin
            case (reg_e'(word[1:0]))
               REG_CTRL:   rd_data = 32'(ctrl[c]);
               REG_COUNT:  rd_data = 32'(count[c]);
               REG_RELOAD: rd_data = 32'(reload[c]);
               default:    rd_data = '0;
            endcase
         end
      end
      if (word == STATUS_WORD) rd_data = 32'(status);
`ifdef PRESCALER_EN
      if (word == PRESCALE_WORD) rd_data = 32'(prescale);
`endif
   end

   always_comb begin
      count_next = count;
      event_hit  = '0;
      for (int c = 0; c < NCH; c++) begin
         if (ctrl[c][CTRL_EN] && tick) begin
            if (!ctrl[c][CTRL_DIR]) begin
               if (count[c] == reload[c]) begin
                  count_next[c] = '0;
                  event_hit[c]  = 1'b1;
               end else begin
                  count_next[c] = count[c] + BITS'(1);
               end
            end else begin
               if (count[c] == '0) begin
                  count_next[c] = reload[c];
                  event_hit[c]  = 1'b1;
               end else begin
                  count_next[c] = count[c] - BITS'(1);
               end
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         tc_o      <= '0;
         status    <= '0;
         // NOTE: these arrays are plain flops, not RAM, so resetting them is intended and cheap.
         for (int c = 0; c < NCH; c++) begin
            ctrl[c]   <= '0;
            count[c]  <= '0;
            reload[c] <= '0;
         end
      end else begin
         wbs_ack_o <= req_new;
         wbs_dat_o <= req_new ? rd_data : '0;
         tc_o      <= event_hit;
         status    <= (status & ~w1c) | event_hit;
         for (int c = 0; c < NCH; c++) begin
            // Bus writes win over counting; the terminal event is still flagged above.
            if (wr && word == 6'(4 * c + 1)) count[c] <= wr_val[BITS-1:0];
            else                             count[c] <= count_next[c];

            if (wr && word == 6'(4 * c))                         ctrl[c] <= wr_val[3:0];
            else if (event_hit[c] && ctrl[c][CTRL_ONESHOT])      ctrl[c][CTRL_EN] <= 1'b0;

            if (wr && word == 6'(4 * c + 2)) reload[c] <= wr_val[BITS-1:0];
         end
      end
   end

   always_comb begin
      count_o = '0;
      ie_vec  = '0;
      for (int c = 0; c < NCH; c++) begin
         count_o[c*BITS +: BITS] = count[c];
         ie_vec[c]               = ctrl[c][CTRL_IE];
      end
   end

   assign irq_o = |(status & ie_vec);

endmodule
